// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch queue.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int FETCH_QUEUE_DEPTH = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_ctrl_if.sv
// Fetch -> queue -> Decode signal bundle; master is the Fetch/Decode side, slave is the queue.
interface fetch_queue_ctrl_if #(parameter int DEPTH = fetch_pkg::FETCH_QUEUE_DEPTH);
  logic                   Flush;
  logic                   InValid;
  logic [1:0]             InCount;
  logic [31:0]            InPCA, InInstrA, InPCB, InInstrB;
  logic                   Stall;
  logic                   OutValidA, OutValidB;
  logic [31:0]            OutPCA, OutInstrA, OutPCB, OutInstrB;
  logic [1:0]             PopCount;
  logic [$clog2(DEPTH):0] Occupancy;

  modport master (
    output Flush, InValid, InCount, InPCA, InInstrA, InPCB, InInstrB, PopCount,
    input  Stall, OutValidA, OutValidB, OutPCA, OutInstrA, OutPCB, OutInstrB, Occupancy
  );

  modport slave (
    input  Flush, InValid, InCount, InPCA, InInstrA, InPCB, InInstrB, PopCount,
    output Stall, OutValidA, OutValidB, OutPCA, OutInstrA, OutPCB, OutInstrB, Occupancy
  );
endinterface

// File: rtl/fetch_queue_ram.sv
// Circular entry storage: two write ports at addr/addr+1, two async reads at raddr/raddr+1. No reset.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic          we1,
  input  logic [PW-1:0] waddr,
  input  fetch_entry_t  wd0,
  input  fetch_entry_t  wd1,
  input  logic [PW-1:0] raddr,
  output fetch_entry_t  rd0,
  output fetch_entry_t  rd1
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] waddr1, raddr1;

  assign waddr1 = waddr + PW'(1);
  assign raddr1 = raddr + PW'(1);

  always_ff @(posedge clk) begin
    if (we0) mem[waddr]  <= wd0;
    if (we1) mem[waddr1] <= wd1;
  end

  assign rd0 = mem[raddr];
  assign rd1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Fetch queue pointer/count control, optional same-cycle bypass, output masking.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let incoming entries reach the outputs in the same cycle.
module fetch_queue_ctrl
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input logic         clk,
  input logic         reset,
  fetch_queue_ctrl_if.slave q
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, avail;
  logic [1:0]    n_in, pushed, pop_req, popped, skip, wr_n;
  logic          stall, push_ok, va, vb;
  fetch_entry_t  in_a, in_b, rd0, rd1, view_a, view_b, wd0;

  assign in_a = '{pc: q.InPCA, instr: q.InInstrA};
  assign in_b = '{pc: q.InPCB, instr: q.InInstrB};

  // Registered-only stall leaves room for a full 2-entry push.
  assign stall   = count > CW'(DEPTH - 2);
  assign push_ok = q.InValid && !stall && !q.Flush;
  assign n_in    = (q.InCount == 2'd0) ? 2'd0 : (q.InCount == 2'd1) ? 2'd1 : 2'd2;
  assign pushed  = push_ok ? n_in : 2'd0;
  assign pop_req = (q.PopCount == 2'd3) ? 2'd2 : q.PopCount;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign avail  = count + CW'(pushed);
  // Incoming entries consumed this cycle never touch storage.
  assign skip   = (CW'(popped) > count) ? popped - count[1:0] : 2'd0;
  assign view_a = (count != '0) ? rd0 : in_a;
  assign view_b = (count >= CW'(2)) ? rd1 : (count == CW'(1)) ? in_a : in_b;
`else
  assign avail  = count;
  assign skip   = 2'd0;
  assign view_a = rd0;
  assign view_b = rd1;
`endif

  assign popped = (CW'(pop_req) > avail) ? avail[1:0] : pop_req;
  assign wr_n   = pushed - skip;
  assign wd0    = (skip == 2'd0) ? in_a : in_b;

  fetch_queue_ram #(.DEPTH(DEPTH), .PW(PW)) u_ram (
    .clk   (clk),
    .we0   (wr_n != 2'd0),
    .we1   (wr_n == 2'd2),
    .waddr (tail),
    .wd0   (wd0),
    .wd1   (in_b),
    .raddr (head),
    .rd0   (rd0),
    .rd1   (rd1)
  );

  always_ff @(posedge clk) begin
    if (reset || q.Flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(popped - skip);
      tail  <= tail + PW'(wr_n);
      count <= count + CW'(pushed) - CW'(popped);
    end
  end

  assign va = avail >= CW'(1);
  assign vb = avail >= CW'(2);

  assign q.Stall     = stall;
  assign q.Occupancy = count;
  assign q.OutValidA = va;
  assign q.OutValidB = vb;
  assign q.OutPCA    = va ? view_a.pc    : '0;
  assign q.OutInstrA = va ? view_a.instr : '0;
  assign q.OutPCB    = vb ? view_b.pc    : '0;
  assign q.OutInstrB = vb ? view_b.instr : '0;

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Randomized and directed bench for fetch_queue_ctrl against a queue-based reference model.
module tb_fetch_queue_ctrl;
  import fetch_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_queue_ctrl_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .q(bus));

  always #5 clk = ~clk;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Model: contents in age order; nq is the contents after the next edge.
  fetch_entry_t mq[$];
  fetch_entry_t nq[$];
  logic                   exp_va, exp_vb, exp_stall;
  logic [31:0]            exp_pca, exp_ia, exp_pcb, exp_ib;
  logic [$clog2(DEPTH):0] exp_occ;

  task automatic drive(input logic fl, input logic v, input logic [1:0] ic, input logic [1:0] pc,
                       input logic [31:0] pa, input logic [31:0] ia, input logic [31:0] pb,
                       input logic [31:0] ib);
    fetch_entry_t comb[$];
    int acc, av, np;
    @(posedge clk);
    mq = nq;
    @(negedge clk);
    bus.Flush = fl; bus.InValid = v; bus.InCount = ic; bus.PopCount = pc;
    bus.InPCA = pa; bus.InInstrA = ia; bus.InPCB = pb; bus.InInstrB = ib;
    #1;
    exp_stall = (mq.size() > DEPTH - 2);
    acc = (v && !exp_stall && !fl) ? ((ic == 0) ? 0 : (ic == 1) ? 1 : 2) : 0;
    comb = mq;
    if (acc >= 1) comb.push_back({pa, ia});
    if (acc >= 2) comb.push_back({pb, ib});
    av = BYPASS ? comb.size() : mq.size();
    exp_va  = (av >= 1);
    exp_vb  = (av >= 2);
    exp_pca = exp_va ? comb[0].pc    : 32'h0;
    exp_ia  = exp_va ? comb[0].instr : 32'h0;
    exp_pcb = exp_vb ? comb[1].pc    : 32'h0;
    exp_ib  = exp_vb ? comb[1].instr : 32'h0;
    exp_occ = mq.size();
    np = (pc == 3) ? 2 : int'(pc);
    if (np > av) np = av;
    repeat (np) void'(comb.pop_front());
    if (fl) comb.delete();
    nq = comb;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.Flush = 1'b0; bus.InValid = 1'b1; bus.InCount = 2'd2; bus.PopCount = 2'd0;
    bus.InPCA = 32'h40; bus.InInstrA = 32'h1; bus.InPCB = 32'h44; bus.InInstrB = 32'h2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.InValid = 1'b0; bus.InCount = 2'd0;
    mq.delete(); nq.delete();
    #1;
    n_tests++;
    if (bus.Occupancy !== '0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", bus.Occupancy); end
    n_tests++;
    if (bus.Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.Stall); end
    n_tests++;
    if ({bus.OutValidA, bus.OutValidB} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid got %b%b want 00", bus.OutValidA, bus.OutValidB);
    end
    n_tests++;
    if ({bus.OutPCA, bus.OutInstrA, bus.OutPCB, bus.OutInstrB} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h %h want 0", bus.OutPCA, bus.OutInstrA, bus.OutPCB, bus.OutInstrB);
    end
  endtask

  task automatic flush_q();
    drive(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_basic_push();
    flush_q();
    drive(1'b0, 1'b1, 2'd2, 2'd0, 32'h0, 32'h11, 32'h4, 32'h22);
    idle();
    n_tests++;
    if (bus.OutPCA !== 32'h0 || bus.OutValidA !== 1'b1) begin
      n_fail++; $display("FAIL basic_pca got %h/%b want 0/1", bus.OutPCA, bus.OutValidA);
    end
    n_tests++;
    if (bus.OutInstrB !== 32'h22) begin n_fail++; $display("FAIL basic_instrb got %h want 22", bus.OutInstrB); end
    n_tests++;
    if (bus.Occupancy !== 4'd2 || bus.Stall !== 1'b0) begin
      n_fail++; $display("FAIL basic_occ got %0d/%b want 2/0", bus.Occupancy, bus.Stall);
    end
  endtask

  task automatic test_fill();
    flush_q();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'd2, 2'd0, 32'(16*i), 32'(i), 32'(16*i+4), 32'(i+100));
      if (i == 3) begin
        n_tests++;
        if (bus.Stall !== 1'b0 || bus.Occupancy !== 4'd6) begin
          n_fail++; $display("FAIL fill_pre got stall %b occ %0d want 0/6", bus.Stall, bus.Occupancy);
        end
      end
    end
    drive(1'b0, 1'b1, 2'd2, 2'd0, 32'h900, 32'h9, 32'h904, 32'h9);
    n_tests++;
    if (bus.Stall !== 1'b1 || bus.Occupancy !== 4'd8) begin
      n_fail++; $display("FAIL fill_full got stall %b occ %0d want 1/8", bus.Stall, bus.Occupancy);
    end
    idle();
    n_tests++;
    if (bus.Occupancy !== 4'd8 || bus.OutPCA !== 32'h0) begin
      n_fail++; $display("FAIL fill_hold got occ %0d pca %h want 8/0", bus.Occupancy, bus.OutPCA);
    end
    // Pop down to 6: stall clears the cycle after.
    drive(1'b0, 1'b0, 2'd0, 2'd2, 32'h0, 32'h0, 32'h0, 32'h0);
    idle();
    n_tests++;
    if (bus.Stall !== 1'b0 || bus.Occupancy !== 4'd6 || bus.OutPCA !== 32'h10) begin
      n_fail++; $display("FAIL fill_drain got stall %b occ %0d pca %h want 0/6/10", bus.Stall, bus.Occupancy, bus.OutPCA);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pc;
    pc = 32'h1000;
    flush_q();
    drive(1'b0, 1'b1, 2'd2, 2'd0, pc, 32'hA0, pc + 4, 32'hA1);
    pc += 8;
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 2'd3, 2'd2, pc, pc ^ 32'hFF, pc + 4, pc ^ 32'hF0);
      if (i >= 3) begin
        n_tests++;
        if (bus.OutPCA !== pc - 8 || bus.OutPCB !== pc - 4 || bus.Occupancy !== 4'd2) begin
          n_fail++; $display("FAIL wrap_%0d got pca %h pcb %h occ %0d want %h %h 2", i, bus.OutPCA, bus.OutPCB, bus.Occupancy, pc - 8, pc - 4);
        end
      end
      pc += 8;
    end
  endtask

  task automatic test_overpop();
    flush_q();
    drive(1'b0, 1'b1, 2'd1, 2'd0, 32'h200, 32'h5, 32'h204, 32'h6);
    drive(1'b0, 1'b0, 2'd0, 2'd2, 32'h0, 32'h0, 32'h0, 32'h0);
    idle();
    n_tests++;
    if (bus.Occupancy !== '0 || bus.OutValidA !== 1'b0 || bus.OutValidB !== 1'b0) begin
      n_fail++; $display("FAIL overpop got occ %0d va %b vb %b want 0 0 0", bus.Occupancy, bus.OutValidA, bus.OutValidB);
    end
    n_tests++;
    if ({bus.OutPCA, bus.OutInstrA, bus.OutPCB, bus.OutInstrB} !== 128'h0) begin
      n_fail++; $display("FAIL overpop_data got %h %h want 0", bus.OutPCA, bus.OutInstrA);
    end
  endtask

  task automatic test_flush();
    flush_q();
    drive(1'b0, 1'b1, 2'd2, 2'd0, 32'h300, 32'h1, 32'h304, 32'h2);
    drive(1'b0, 1'b1, 2'd2, 2'd0, 32'h308, 32'h3, 32'h30C, 32'h4);
    drive(1'b0, 1'b1, 2'd1, 2'd0, 32'h310, 32'h5, 32'h314, 32'h6);
    drive(1'b1, 1'b1, 2'd2, 2'd1, 32'h318, 32'h7, 32'h31C, 32'h8);
    n_tests++;
    if (bus.Occupancy !== 4'd5) begin n_fail++; $display("FAIL flush_pre got occ %0d want 5", bus.Occupancy); end
    idle();
    n_tests++;
    if (bus.Occupancy !== '0 || bus.OutValidA !== 1'b0 || bus.Stall !== 1'b0) begin
      n_fail++; $display("FAIL flush got occ %0d va %b stall %b want 0 0 0", bus.Occupancy, bus.OutValidA, bus.Stall);
    end
  endtask

  task automatic test_bypass();
    flush_q();
    drive(1'b0, 1'b1, 2'd2, 2'd1, 32'h100, 32'hAA, 32'h104, 32'hBB);
    n_tests++;
    if (BYPASS) begin
      if (bus.OutPCA !== 32'h100 || bus.OutValidB !== 1'b1) begin
        n_fail++; $display("FAIL bypass_same got pca %h vb %b want 100 1", bus.OutPCA, bus.OutValidB);
      end
    end else if (bus.OutValidA !== 1'b0) begin
      n_fail++; $display("FAIL bypass_off got va %b want 0", bus.OutValidA);
    end
    idle();
    n_tests++;
    if (BYPASS) begin
      if (bus.OutPCA !== 32'h104 || bus.OutInstrA !== 32'hBB || bus.Occupancy !== 4'd1) begin
        n_fail++; $display("FAIL bypass_next got pca %h ia %h occ %0d want 104 BB 1", bus.OutPCA, bus.OutInstrA, bus.Occupancy);
      end
    end else if (bus.OutPCA !== 32'h100 || bus.Occupancy !== 4'd2) begin
      n_fail++; $display("FAIL bypass_off_next got pca %h occ %0d want 100 2", bus.OutPCA, bus.Occupancy);
    end
  endtask

  task automatic test_random();
    flush_q();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), pc, $urandom, pc + 4, $urandom);
      n_tests++;
      if (bus.OutValidA !== exp_va || bus.OutValidB !== exp_vb) begin
        n_fail++; $display("FAIL rnd_valid[%0d] got %b%b want %b%b", i, bus.OutValidA, bus.OutValidB, exp_va, exp_vb);
      end
      n_tests++;
      if (bus.OutPCA !== exp_pca || bus.OutInstrA !== exp_ia) begin
        n_fail++; $display("FAIL rnd_a[%0d] got %h/%h want %h/%h", i, bus.OutPCA, bus.OutInstrA, exp_pca, exp_ia);
      end
      n_tests++;
      if (bus.OutPCB !== exp_pcb || bus.OutInstrB !== exp_ib) begin
        n_fail++; $display("FAIL rnd_b[%0d] got %h/%h want %h/%h", i, bus.OutPCB, bus.OutInstrB, exp_pcb, exp_ib);
      end
      n_tests++;
      if (bus.Stall !== exp_stall || bus.Occupancy !== exp_occ) begin
        n_fail++; $display("FAIL rnd_state[%0d] got stall %b occ %0d want %b %0d", i, bus.Stall, bus.Occupancy, exp_stall, exp_occ);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_fill();
    test_wrap();
    test_overpop();
    test_flush();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
